// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
// Optional parity storage elsewhere is enabled with `UNIV_SHREG_PARITY_EN.
package univ_shreg_pkg;

  localparam logic [1:0] ENC_HOLD = 2'b00;
  localparam logic [1:0] ENC_SHUP = 2'b01;
  localparam logic [1:0] ENC_SHDN = 2'b10;
  localparam logic [1:0] ENC_LOAD = 2'b11;

  typedef enum logic [1:0] {
    MODE_HOLD = ENC_HOLD,
    MODE_SHUP = ENC_SHUP,
    MODE_SHDN = ENC_SHDN,
    MODE_LOAD = ENC_LOAD
  } mode_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle between a controller and the universal shift register.
// The par_out signal exists only when `UNIV_SHREG_PARITY_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       sin_lo;
  logic [WIDTH-1:0]       sin_hi;
  logic [DEPTH*WIDTH-1:0] pin;
  logic [DEPTH*WIDTH-1:0] pout;
  logic [WIDTH-1:0]       sout_hi;
  logic [WIDTH-1:0]       sout_lo;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
`ifdef UNIV_SHREG_PARITY_EN
  logic [DEPTH-1:0]       par_out;

  modport master (
    output en, mode, sin_lo, sin_hi, pin,
    input  pout, sout_hi, sout_lo, count, full, empty, par_out
  );

  modport slave (
    input  en, mode, sin_lo, sin_hi, pin,
    output pout, sout_hi, sout_lo, count, full, empty, par_out
  );
`else
  modport master (
    output en, mode, sin_lo, sin_hi, pin,
    input  pout, sout_hi, sout_lo, count, full, empty
  );

  modport slave (
    input  en, mode, sin_lo, sin_hi, pin,
    output pout, sout_hi, sout_lo, count, full, empty
  );
`endif

endinterface

// File: rtl/univ_shift_reg_stage.sv
// One word of the shift chain: a 4:1 next-value mux feeding an async-reset flop.
// With `UNIV_SHREG_PARITY_EN a parity bit is captured alongside each written word.
module shreg_stage
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] pin_in,
`ifdef UNIV_SHREG_PARITY_EN
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      case (mode)
        MODE_SHUP: data_d = lo_in;
        MODE_SHDN: data_d = hi_in;
        MODE_LOAD: data_d = pin_in;
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

`ifdef UNIV_SHREG_PARITY_EN
  logic par_d;
  logic par_q;

  // Parity of whatever word lands here, so it moves with the word on every shift.
  always_comb begin
    par_d = par_q;
    if (en && (mode != MODE_HOLD)) begin
      par_d = ^data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/univ_shift_reg.sv
// DEPTH-stage shift/load register with saturating occupancy counter.
// Define `UNIV_SHREG_PARITY_EN to add per-stage parity on bus.par_out.
module univ_shift_reg
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  univ_shift_reg_if.slave  bus
);

  localparam int CW = occ_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  mode_t            mode;
  logic [WIDTH-1:0] stage_w [DEPTH];
  logic [WIDTH-1:0] lo_w    [DEPTH];
  logic [WIDTH-1:0] hi_w    [DEPTH];
  logic [DEPTH*WIDTH-1:0] pout_w;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  assign mode = mode_t'(bus.mode);

`ifdef UNIV_SHREG_PARITY_EN
  logic [DEPTH-1:0] par_w;
`endif

  // Stage 0 is the low end: SHUP feeds it from sin_lo, SHDN feeds the top from sin_hi.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_lo_end
      assign lo_w[k] = bus.sin_lo;
    end else begin : g_lo_mid
      assign lo_w[k] = stage_w[k-1];
    end

    if (k == DEPTH - 1) begin : g_hi_end
      assign hi_w[k] = bus.sin_hi;
    end else begin : g_hi_mid
      assign hi_w[k] = stage_w[k+1];
    end

    shreg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en),
      .mode   (mode),
      .lo_in  (lo_w[k]),
      .hi_in  (hi_w[k]),
      .pin_in (bus.pin[k*WIDTH +: WIDTH]),
`ifdef UNIV_SHREG_PARITY_EN
      .par_o  (par_w[k]),
`endif
      .data_o (stage_w[k])
    );
  end

  always_comb begin
    pout_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pout_w[k*WIDTH +: WIDTH] = stage_w[k];
    end
  end

  // Count follows words moved in or out, saturating at both ends.
  always_comb begin
    count_d = count_q;
    if (bus.en) begin
      case (mode)
        MODE_SHUP: if (count_q != FULL_CNT) count_d = count_q + CW'(1);
        MODE_SHDN: if (count_q != '0)       count_d = count_q - CW'(1);
        MODE_LOAD: count_d = FULL_CNT;
        default:   count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.pout    = pout_w;
  assign bus.sout_hi = stage_w[DEPTH-1];
  assign bus.sout_lo = stage_w[0];
  assign bus.count   = count_q;
  assign bus.full    = (count_q == FULL_CNT);
  assign bus.empty   = (count_q == '0);
`ifdef UNIV_SHREG_PARITY_EN
  assign bus.par_out = par_w;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized traffic
// compared every cycle against a packed-vector reference model.
module tb_univ_shift_reg;
  import univ_shreg_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = DEPTH * WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  univ_shift_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: the whole register as one vector, stage 0 in the low bits.
  logic [PW-1:0] m_word;
  int            m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word  <= '0;
      m_count <= 0;
    end else if (bus.en) begin
      case (bus.mode)
        ENC_SHUP: begin
          m_word  <= {m_word[PW-WIDTH-1:0], bus.sin_lo};
          m_count <= (m_count >= DEPTH) ? DEPTH : m_count + 1;
        end
        ENC_SHDN: begin
          m_word  <= {bus.sin_hi, m_word[PW-1:WIDTH]};
          m_count <= (m_count <= 0) ? 0 : m_count - 1;
        end
        ENC_LOAD: begin
          m_word  <= bus.pin;
          m_count <= DEPTH;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.en) begin
      assert (!$isunknown(bus.mode)) else $error("[TB] mode unknown while enabled");
    end
  end

  function automatic logic [DEPTH-1:0] model_parity(input logic [PW-1:0] w);
    logic [DEPTH-1:0] p;
    for (int k = 0; k < DEPTH; k++) p[k] = ^w[k*WIDTH +: WIDTH];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the reference model.
  always @(negedge clk) begin
    checkOutput("pout",    64'(bus.pout),    64'(m_word));
    checkOutput("sout_hi", 64'(bus.sout_hi), 64'(m_word[PW-1 -: WIDTH]));
    checkOutput("sout_lo", 64'(bus.sout_lo), 64'(m_word[WIDTH-1:0]));
    checkOutput("count",   64'(bus.count),   64'(m_count));
    checkOutput("full",    64'(bus.full),    64'(m_count == DEPTH));
    checkOutput("empty",   64'(bus.empty),   64'(m_count == 0));
`ifdef UNIV_SHREG_PARITY_EN
    checkOutput("par_out", 64'(bus.par_out), 64'(model_parity(m_word)));
`endif
  end

  task automatic applyStimulus(input logic e, input logic [1:0] md,
                               input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                               input logic [PW-1:0] p);
    bus.en     = e;
    bus.mode   = md;
    bus.sin_lo = lo;
    bus.sin_hi = hi;
    bus.pin    = p;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] up_words [5];
  logic [WIDTH-1:0] dn_lo    [5];
  int               dn_cnt   [5];

  initial begin
    up_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    dn_lo    = '{8'h33, 8'h22, 8'h11, 8'h00, 8'h00};
    dn_cnt   = '{3, 2, 1, 0, 0};

    bus.en = 1'b0; bus.mode = ENC_HOLD; bus.sin_lo = '0; bus.sin_hi = '0; bus.pin = '0;

    // Reset state, held across clocks even with a load requested.
    #1;
    checkOutput("rst_pout",  64'(bus.pout),  64'h0);
    checkOutput("rst_count", 64'(bus.count), 64'h0);
    checkOutput("rst_empty", 64'(bus.empty), 64'h1);
    checkOutput("rst_full",  64'(bus.full),  64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ENC_LOAD, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
    checkOutput("rst_hold_pout", 64'(bus.pout), 64'h0);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    applyStimulus(1'b0, ENC_HOLD, '0, '0, '0);

    // Fill by shifting up, then one more shift saturates the count.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, ENC_SHUP, up_words[i], 8'h00, '0);
    checkOutput("shup4_pout",  64'(bus.pout),  64'hA1B2C3D4);
    checkOutput("shup4_count", 64'(bus.count), 64'd4);
    checkOutput("shup4_full",  64'(bus.full),  64'h1);
    applyStimulus(1'b1, ENC_SHUP, up_words[4], 8'h00, '0);
    checkOutput("shup5_pout",    64'(bus.pout),    64'hB2C3D4E5);
    checkOutput("shup5_sout_hi", 64'(bus.sout_hi), 64'hB2);
    checkOutput("shup5_count",   64'(bus.count),   64'd4);

    // Parallel load, then a disabled load must not disturb it.
    applyStimulus(1'b1, ENC_LOAD, '0, '0, 32'h11223344);
    checkOutput("load_pout",  64'(bus.pout),  64'h11223344);
    checkOutput("load_count", 64'(bus.count), 64'd4);
    applyStimulus(1'b0, ENC_LOAD, '0, '0, 32'h0);
    checkOutput("en0_pout", 64'(bus.pout), 64'h11223344);

    // Drain by shifting down; count floors at zero.
    checkOutput("shdn0_sout_lo", 64'(bus.sout_lo), 64'h44);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ENC_SHDN, 8'h00, 8'h00, '0);
      checkOutput("shdn_sout_lo", 64'(bus.sout_lo), 64'(dn_lo[i]));
      checkOutput("shdn_count",   64'(bus.count),   64'(dn_cnt[i]));
    end
    checkOutput("shdn_empty", 64'(bus.empty), 64'h1);

    // Asynchronous reset between edges clears everything immediately.
    applyStimulus(1'b1, ENC_SHUP, 8'h5A, 8'h00, '0);
    applyStimulus(1'b1, ENC_SHUP, 8'hA5, 8'h00, '0);
    checkOutput("mid_count_pre", 64'(bus.count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pout",  64'(bus.pout),  64'h0);
    checkOutput("mid_rst_count", 64'(bus.count), 64'h0);
    checkOutput("mid_rst_empty", 64'(bus.empty), 64'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef UNIV_SHREG_PARITY_EN
    // Stage words 07,00,03,01: odd ones only in stages 0 and 3.
    applyStimulus(1'b1, ENC_LOAD, '0, '0, 32'h01030007);
    checkOutput("par_load", 64'(bus.par_out), 64'b1001);
    applyStimulus(1'b1, ENC_SHUP, 8'h00, 8'h00, '0);
    checkOutput("par_shup", 64'(bus.par_out), 64'b0010);
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    WIDTH'($urandom), WIDTH'($urandom), PW'($urandom));
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    applyStimulus(1'b0, ENC_HOLD, '0, '0, '0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
